voice_allocator: RTL and testbench

- Bus master that turns note-on/note-off requests into write sequences on the synth register bus.
- Owns NUM_VOICES voice slots. Picks a free voice, or steals one when all are busy.
- Programs the voice's register block from the current patch inputs, then opens or closes its gate.
- Sits between the control front end and TopLevel's BusAddress/BusData/BusReadWrite/BusClock inputs; replaces hand-sequenced bus writes.

---
 rtl/synth_bus_pkg.sv | 23 ++
 rtl/bus_write_master.sv | 69 ++++++
 rtl/voice_allocator.sv | 241 ++++++++++++++++++++++++
 tb/tb_voice_allocator.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/synth_bus_pkg.sv
// Shared constants and state types for synth register bus masters:
// voice register offsets, voice block stride, gate values and FSM encodings.
package synth_bus_pkg;

    localparam logic [3:0] OFS_GATE    = 4'd0;
    localparam logic [3:0] OFS_INCR    = 4'd1;
    localparam logic [3:0] OFS_WAVE    = 4'd2;
    localparam logic [3:0] OFS_PULSE   = 4'd3;
    localparam logic [3:0] OFS_ATTACK  = 4'd4;
    localparam logic [3:0] OFS_DECAY   = 4'd5;
    localparam logic [3:0] OFS_SUSTAIN = 4'd6;
    localparam logic [3:0] OFS_RELEASE = 4'd7;
    localparam logic [3:0] OFS_LINEAR  = 4'd8;

    localparam logic [15:0] VOICE_STRIDE = 16'h0010;

    localparam logic [7:0] GATE_OPEN  = 8'h01;
    localparam logic [7:0] GATE_CLOSE = 8'h00;

    typedef enum logic [1:0] {A_IDLE, A_LOOKUP, A_WRITE} alloc_state_t;
    typedef enum logic [1:0] {W_IDLE, W_SETUP, W_STROBE, W_HOLD} wr_state_t;

endpackage

// File: rtl/bus_write_master.sv
// Single-write SETUP/STROBE/HOLD engine for the synth register bus.
// A start seen in IDLE or HOLD launches the next write back-to-back.
module bus_write_master
    import synth_bus_pkg::*;
#(
    parameter int STROBE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] addr,
    input  logic [7:0]  data,
    output logic        done,
    output logic [15:0] bus_address,
    output logic [7:0]  bus_write_data,
    output logic        bus_read_write,
    output logic        bus_clock
);

    localparam int CNT_W = $clog2(STROBE_CYCLES + 1);

    wr_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [15:0]      addr_q;
    logic [7:0]       data_q;
    logic             take;

    assign take = start && (state_q == W_IDLE || state_q == W_HOLD);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= W_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == W_SETUP)
                cnt_q <= '0;
            else if (state_q == W_STROBE)
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (take) begin
            addr_q <= addr;
            data_q <= data;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            W_IDLE:   if (start) state_d = W_SETUP;
            W_SETUP:  state_d = W_STROBE;
            W_STROBE: if (cnt_q == CNT_W'(STROBE_CYCLES - 1)) state_d = W_HOLD;
            W_HOLD:   state_d = start ? W_SETUP : W_IDLE;
            default:  state_d = W_IDLE;
        endcase
    end

    assign done           = (state_q == W_HOLD);
    assign bus_read_write = (state_q != W_IDLE);
    assign bus_clock      = (state_q == W_STROBE);
    assign bus_address    = bus_read_write ? addr_q : '0;
    assign bus_write_data = bus_read_write ? data_q : '0;

endmodule

// File: rtl/voice_allocator.sv
// Turns note-on/note-off requests into voice register write sequences.
// Define VOICE_ALLOC_STEAL_EN to steal a busy voice instead of dropping the note.
module voice_allocator
    import synth_bus_pkg::*;
#(
    parameter int NUM_VOICES    = 2,
    parameter int STROBE_CYCLES = 1
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  ReqValid,
    output logic                  ReqReady,
    input  logic                  ReqGate,
    input  logic [6:0]            ReqKey,
    input  logic [7:0]            ReqIncr,
    input  logic [7:0]            PatchWave,
    input  logic [7:0]            PatchPulse,
    input  logic [7:0]            PatchAttack,
    input  logic [7:0]            PatchDecay,
    input  logic [7:0]            PatchSustain,
    input  logic [7:0]            PatchRelease,
    input  logic                  PatchLinear,
    output logic [15:0]           BusAddress,
    output logic [7:0]            BusWriteData,
    output logic                  BusReadWrite,
    output logic                  BusClock,
    output logic [NUM_VOICES-1:0] VoiceActive,
    output logic                  Dropped
);

    localparam int VIDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    // Write-list steps: 0 closes the gate, 1..8 program offsets 1..8, 9 opens the gate.
    localparam logic [3:0] STEP_CLOSE = 4'd0;
    localparam logic [3:0] STEP_PATCH = 4'd1;
    localparam logic [3:0] STEP_OPEN  = 4'd9;

    alloc_state_t         state_q, state_d;
    logic                 sh_gate, sh_linear;
    logic [6:0]           sh_key;
    logic [7:0]           sh_incr, sh_wave, sh_pulse, sh_attack, sh_decay, sh_sustain, sh_release;
    logic [NUM_VOICES-1:0] active_q;
    logic [6:0]           key_tab [NUM_VOICES];
    logic [VIDX_W-1:0]    voice_q;
    logic [3:0]           step_q, last_q;

    logic                 match_hit, free_hit;
    logic [VIDX_W-1:0]    match_idx, free_idx;
    logic                 sel_go;
    logic [VIDX_W-1:0]    sel_voice;
    logic [3:0]           sel_first, sel_last;

    logic                 wr_start, wr_done;
    logic [VIDX_W-1:0]    wr_voice;
    logic [3:0]           wr_step, wr_ofs;
    logic [15:0]          wr_addr;
    logic [7:0]           wr_data;
    logic                 write_end;

`ifdef VOICE_ALLOC_STEAL_EN
    logic [VIDX_W-1:0]    steal_ptr_q;
    logic                 steal_take;
`else
    logic                 drop_req;
`endif

    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        free_hit  = 1'b0;
        free_idx  = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (active_q[i] && key_tab[i] == sh_key) begin
                match_hit = 1'b1;
                match_idx = VIDX_W'(i);
            end
            if (!active_q[i]) begin
                free_hit = 1'b1;
                free_idx = VIDX_W'(i);
            end
        end
    end

    always_comb begin
        sel_go    = 1'b0;
        sel_voice = match_idx;
        sel_first = STEP_CLOSE;
        sel_last  = STEP_CLOSE;
`ifdef VOICE_ALLOC_STEAL_EN
        steal_take = 1'b0;
`else
        drop_req   = 1'b0;
`endif
        if (sh_gate) begin
            sel_first = STEP_PATCH;
            sel_last  = STEP_OPEN;
            if (match_hit) begin
                sel_go = 1'b1;
            end else if (free_hit) begin
                sel_go    = 1'b1;
                sel_voice = free_idx;
            end else begin
`ifdef VOICE_ALLOC_STEAL_EN
                sel_go     = 1'b1;
                sel_voice  = steal_ptr_q;
                sel_first  = STEP_CLOSE;
                steal_take = 1'b1;
`else
                drop_req   = 1'b1;
`endif
            end
        end else begin
            sel_go = match_hit;
        end
    end

    always_comb begin
        state_d  = state_q;
        ReqReady = (state_q == A_IDLE) && !Reset;
        wr_start = 1'b0;
        wr_voice = voice_q;
        wr_step  = step_q + 4'd1;
        case (state_q)
            A_IDLE:   if (ReqValid && ReqReady) state_d = A_LOOKUP;
            A_LOOKUP: begin
                wr_voice = sel_voice;
                wr_step  = sel_first;
                wr_start = sel_go;
                state_d  = sel_go ? A_WRITE : A_IDLE;
            end
            A_WRITE:  begin
                if (wr_done) begin
                    if (step_q != last_q) wr_start = 1'b1;
                    else                  state_d  = A_IDLE;
                end
            end
            default:  state_d = A_IDLE;
        endcase
    end

    always_comb begin
        wr_ofs  = OFS_GATE;
        wr_data = GATE_OPEN;
        case (wr_step)
            STEP_CLOSE: wr_data = GATE_CLOSE;
            4'd1: begin wr_ofs = OFS_INCR;    wr_data = sh_incr;    end
            4'd2: begin wr_ofs = OFS_WAVE;    wr_data = sh_wave;    end
            4'd3: begin wr_ofs = OFS_PULSE;   wr_data = sh_pulse;   end
            4'd4: begin wr_ofs = OFS_ATTACK;  wr_data = sh_attack;  end
            4'd5: begin wr_ofs = OFS_DECAY;   wr_data = sh_decay;   end
            4'd6: begin wr_ofs = OFS_SUSTAIN; wr_data = sh_sustain; end
            4'd7: begin wr_ofs = OFS_RELEASE; wr_data = sh_release; end
            4'd8: begin wr_ofs = OFS_LINEAR;  wr_data = {7'b0, sh_linear}; end
            default: ;
        endcase
    end

    assign wr_addr   = VOICE_STRIDE * (16'(wr_voice) + 16'd1) + {12'd0, wr_ofs};
    assign write_end = (state_q == A_WRITE) && wr_done;

    always_ff @(posedge Clock) begin
        if (Reset) state_q <= A_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge Clock) begin
        if (ReqValid && ReqReady) begin
            sh_gate    <= ReqGate;
            sh_key     <= ReqKey;
            sh_incr    <= ReqIncr;
            sh_wave    <= PatchWave;
            sh_pulse   <= PatchPulse;
            sh_attack  <= PatchAttack;
            sh_decay   <= PatchDecay;
            sh_sustain <= PatchSustain;
            sh_release <= PatchRelease;
            sh_linear  <= PatchLinear;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            active_q <= '0;
            voice_q  <= '0;
            step_q   <= '0;
            last_q   <= '0;
        end else begin
            if (state_q == A_LOOKUP) begin
                voice_q <= sel_voice;
                last_q  <= sel_last;
            end
            if (wr_start) step_q <= wr_step;
            if (write_end) begin
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (voice_q == VIDX_W'(i)) begin
                        if (step_q == STEP_OPEN)       active_q[i] <= 1'b1;
                        else if (step_q == STEP_CLOSE) active_q[i] <= 1'b0;
                    end
                end
            end
        end
    end

    // NOTE: the key table is not reset; an entry is only read while its active bit is set.
    always_ff @(posedge Clock) begin
        if (write_end && step_q == STEP_OPEN) begin
            for (int i = 0; i < NUM_VOICES; i++)
                if (voice_q == VIDX_W'(i)) key_tab[i] <= sh_key;
        end
    end

`ifdef VOICE_ALLOC_STEAL_EN
    always_ff @(posedge Clock) begin
        if (Reset)
            steal_ptr_q <= '0;
        else if (state_q == A_LOOKUP && steal_take)
            steal_ptr_q <= (steal_ptr_q == VIDX_W'(NUM_VOICES - 1)) ? '0 : steal_ptr_q + VIDX_W'(1);
    end

    assign Dropped = 1'b0;
`else
    assign Dropped = (state_q == A_LOOKUP) && drop_req;
`endif

    assign VoiceActive = active_q;

    bus_write_master #(
        .STROBE_CYCLES(STROBE_CYCLES)
    ) u_write (
        .clk            (Clock),
        .rst            (Reset),
        .start          (wr_start),
        .addr           (wr_addr),
        .data           (wr_data),
        .done           (wr_done),
        .bus_address    (BusAddress),
        .bus_write_data (BusWriteData),
        .bus_read_write (BusReadWrite),
        .bus_clock      (BusClock)
    );

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: table of note requests with hand-picked
// expected voices, plus reset and mid-sequence reset sequences.
module tb_voice_allocator;

    localparam int NV = 2;
    localparam int SC = 1;

    logic        clk = 1'b0;
    logic        Reset, ReqValid, ReqReady, ReqGate, PatchLinear;
    logic [6:0]  ReqKey;
    logic [7:0]  ReqIncr, PatchWave, PatchPulse, PatchAttack, PatchDecay, PatchSustain, PatchRelease;
    logic [15:0] BusAddress;
    logic [7:0]  BusWriteData;
    logic        BusReadWrite, BusClock, Dropped;
    logic [NV-1:0] VoiceActive;

    always #5 clk = ~clk;

    voice_allocator #(.NUM_VOICES(NV), .STROBE_CYCLES(SC)) dut (
        .Clock(clk), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqGate(ReqGate), .ReqKey(ReqKey), .ReqIncr(ReqIncr),
        .PatchWave(PatchWave), .PatchPulse(PatchPulse), .PatchAttack(PatchAttack),
        .PatchDecay(PatchDecay), .PatchSustain(PatchSustain), .PatchRelease(PatchRelease),
        .PatchLinear(PatchLinear), .BusAddress(BusAddress), .BusWriteData(BusWriteData),
        .BusReadWrite(BusReadWrite), .BusClock(BusClock), .VoiceActive(VoiceActive),
        .Dropped(Dropped)
    );

    typedef struct {
        bit          gate;
        logic [6:0]  key;
        logic [7:0]  incr;
        logic [47:0] patch;   // wave, pulse, attack, decay, sustain, release
        bit          lin;
        int          exp_voice;   // -1: no writes expected
        bit          exp_steal;
        logic [1:0]  exp_active;
        bit          exp_drop;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] exp_addr[$];
    logic [7:0]  exp_data[$];
    logic [15:0] got_addr[$];
    logic [7:0]  got_data[$];
    int          got_width[$];
    int          ready_n, drop_n, drop_cyc;
    bit          rw_bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit g, logic [6:0] k, logic [7:0] inc, logic [47:0] p, bit lin,
                                int ev, bit es, logic [1:0] ea, bit ed);
        vec_t v;
        v.gate = g; v.key = k; v.incr = inc; v.patch = p; v.lin = lin;
        v.exp_voice = ev; v.exp_steal = es; v.exp_active = ea; v.exp_drop = ed;
        return v;
    endfunction

    task automatic build_exp(input vec_t v);
        logic [15:0] base;
        logic [47:0] p;
        exp_addr.delete();
        exp_data.delete();
        if (v.exp_voice < 0) return;
        base = 16'((v.exp_voice + 1) * 16);
        p = v.patch;
        if (!v.gate || v.exp_steal) begin
            exp_addr.push_back(base); exp_data.push_back(8'h00);
        end
        if (v.gate) begin
            exp_addr.push_back(base + 16'd1); exp_data.push_back(v.incr);
            exp_addr.push_back(base + 16'd2); exp_data.push_back(p[47:40]);
            exp_addr.push_back(base + 16'd3); exp_data.push_back(p[39:32]);
            exp_addr.push_back(base + 16'd4); exp_data.push_back(p[31:24]);
            exp_addr.push_back(base + 16'd5); exp_data.push_back(p[23:16]);
            exp_addr.push_back(base + 16'd6); exp_data.push_back(p[15:8]);
            exp_addr.push_back(base + 16'd7); exp_data.push_back(p[7:0]);
            exp_addr.push_back(base + 16'd8); exp_data.push_back({7'b0, v.lin});
            exp_addr.push_back(base);         exp_data.push_back(8'h01);
        end
    endtask

    task automatic drive(input vec_t v);
        ReqValid = 1'b1; ReqGate = v.gate; ReqKey = v.key; ReqIncr = v.incr;
        {PatchWave, PatchPulse, PatchAttack, PatchDecay, PatchSustain, PatchRelease} = v.patch;
        PatchLinear = v.lin;
    endtask

    task automatic scramble(input vec_t v);
        ReqValid = 1'b0; ReqGate = ~v.gate; ReqKey = v.key ^ 7'h55; ReqIncr = ~v.incr;
        {PatchWave, PatchPulse, PatchAttack, PatchDecay, PatchSustain, PatchRelease} = ~v.patch;
        PatchLinear = ~v.lin;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!ReqReady && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, " ready_before_req"}, 32'(ReqReady), 32'd1);
    endtask

    task automatic run_req(input vec_t v, input string tag);
        bit prev = 1'b0;
        int w = 0;
        int bad_w = 0;
        wait_ready(tag);
        drive(v);
        @(posedge clk);
        #1;
        scramble(v);
        got_addr.delete(); got_data.delete(); got_width.delete();
        ready_n = -1; drop_n = 0; drop_cyc = -1; rw_bad = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (Dropped) begin drop_n++; drop_cyc = c; end
            if (BusClock) begin
                if (!prev) begin
                    got_addr.push_back(BusAddress);
                    got_data.push_back(BusWriteData);
                    w = 0;
                end else if (BusAddress !== got_addr[$] || BusWriteData !== got_data[$]) begin
                    rw_bad = 1'b1;
                end
                w++;
                if (!BusReadWrite) rw_bad = 1'b1;
            end else if (prev) begin
                got_width.push_back(w);
            end
            prev = BusClock;
            if (ReqReady) begin ready_n = c; break; end
        end
        build_exp(v);
        check({tag, " ready_cycle"}, 32'(ready_n), 32'(2 + exp_addr.size() * (2 + SC)));
        check({tag, " write_count"}, 32'(got_addr.size()), 32'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++)
            check($sformatf("%s write%0d addr_data", tag, i),
                  {8'h00, got_addr[i], got_data[i]}, {8'h00, exp_addr[i], exp_data[i]});
        foreach (got_width[i]) if (got_width[i] != SC) bad_w++;
        check({tag, " strobe_width"}, 32'(bad_w), 32'd0);
        check({tag, " bus_stable"}, 32'(rw_bad), 32'd0);
        check({tag, " voice_active"}, 32'(VoiceActive), 32'(v.exp_active));
        check({tag, " dropped_count"}, 32'(drop_n), 32'(v.exp_drop));
        if (v.exp_drop) check({tag, " dropped_cycle"}, 32'(drop_cyc), 32'd1);
    endtask

    task automatic do_reset(input string tag);
        Reset = 1'b1;
        repeat (2) @(negedge clk);
        check({tag, " outputs_in_reset"},
              {5'd0, BusAddress, BusWriteData, BusReadWrite, BusClock, Dropped, ReqReady},
              32'd0);
        check({tag, " active_in_reset"}, 32'(VoiceActive), 32'd0);
        Reset = 1'b0;
        @(negedge clk);
        check({tag, " ready_after_reset"}, 32'(ReqReady), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[9];
        vec_t v;
        tbl[0] = mk(1, 7'd60, 8'h0F, 48'h01_3F_02_05_7F_05, 1,  0, 0, 2'b01, 0);
        tbl[1] = mk(1, 7'd64, 8'h22, 48'h03_10_04_06_40_08, 0,  1, 0, 2'b11, 0);
        tbl[2] = mk(1, 7'd60, 8'h11, 48'h02_20_01_01_10_02, 1,  0, 0, 2'b11, 0);
        tbl[3] = mk(0, 7'd60, 8'h00, 48'h0,                 0,  0, 0, 2'b10, 0);
        tbl[4] = mk(0, 7'd10, 8'h00, 48'h0,                 0, -1, 0, 2'b10, 0);
        tbl[5] = mk(1, 7'd70, 8'h33, 48'hA1_B2_C3_D4_E5_F6, 0,  0, 0, 2'b11, 0);
`ifdef VOICE_ALLOC_STEAL_EN
        tbl[6] = mk(1, 7'd72, 8'h44, 48'h11_22_33_44_55_66, 1,  0, 1, 2'b11, 0);
        tbl[7] = mk(1, 7'd74, 8'h55, 48'h66_55_44_33_22_11, 0,  1, 1, 2'b11, 0);
        tbl[8] = mk(0, 7'd74, 8'h00, 48'h0,                 0,  1, 0, 2'b01, 0);
`else
        tbl[6] = mk(1, 7'd72, 8'h44, 48'h11_22_33_44_55_66, 1, -1, 0, 2'b11, 1);
        tbl[7] = mk(1, 7'd74, 8'h55, 48'h66_55_44_33_22_11, 0, -1, 0, 2'b11, 1);
        tbl[8] = mk(0, 7'd74, 8'h00, 48'h0,                 0, -1, 0, 2'b11, 0);
`endif
        Reset = 1'b1; ReqValid = 1'b0; ReqGate = 1'b0; ReqKey = '0; ReqIncr = '0;
        PatchWave = '0; PatchPulse = '0; PatchAttack = '0; PatchDecay = '0;
        PatchSustain = '0; PatchRelease = '0; PatchLinear = 1'b0;
        @(negedge clk);
        do_reset("init");

        for (int i = 0; i < 9; i++)
            run_req(tbl[i], $sformatf("vec%0d", i));

        // Reset in the middle of voice 1's fourth write
        do_reset("pre_abort");
        run_req(mk(1, 7'd80, 8'h0A, 48'h01_02_03_04_05_06, 0, 0, 0, 2'b01, 0), "abort_setup");
        wait_ready("abort");
        v = mk(1, 7'd81, 8'h0B, 48'h07_08_09_0A_0B_0C, 1, 1, 0, 2'b01, 0);
        drive(v);
        @(posedge clk);
        #1;
        scramble(v);
        repeat (12) @(negedge clk);
        check("abort strobe_of_4th_write", {15'd0, BusClock, BusAddress}, {15'd0, 1'b1, 16'h0024});
        check("abort data_of_4th_write", 32'(BusWriteData), 32'h09);
        Reset = 1'b1;
        @(negedge clk);
        check("abort outputs_after_reset",
              {5'd0, BusAddress, BusWriteData, BusReadWrite, BusClock, Dropped, ReqReady},
              32'd0);
        check("abort active_after_reset", 32'(VoiceActive), 32'd0);
        Reset = 1'b0;
        @(negedge clk);
        run_req(mk(1, 7'd5, 8'h5A, 48'h0F_1E_2D_3C_4B_5A, 1, 0, 0, 2'b01, 0), "post_abort");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
